// File: rtl/damage_resolver_if.sv
// Damage handshake between the Machine (master) and the damage resolver (slave).
// The Machine side also carries the frame strobe and the collision/pickup pulses.
interface damage_resolver_if;
  logic       startDmg;
  logic [7:0] monATK;
  logic       tick;
  logic       playerHit;
  logic       healPickup;
  logic       isDmgComplete;
  logic [7:0] damage;
  logic       heal;
  logic       busy;
  logic [7:0] framesLeft;

  modport master (
    output startDmg, monATK, tick, playerHit, healPickup,
    input  isDmgComplete, damage, heal, busy, framesLeft
  );

  modport slave (
    input  startDmg, monATK, tick, playerHit, healPickup,
    output isDmgComplete, damage, heal, busy, framesLeft
  );
endinterface

// File: rtl/damage_resolver.sv
// Runs the monster attack window: counts frames, accepts hits behind a cooldown,
// accumulates saturating damage and reports damage/heal with a one-cycle pulse.
module damage_resolver #(
  parameter int WINDOW_FRAMES = 120,
  parameter int HIT_COOLDOWN  = 8
) (
  input logic               clk,
  input logic               reset,
  damage_resolver_if.slave  dmg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    DODGE  = 2'd2,
    REPORT = 2'd3
  } state_e;

  localparam logic [7:0] WIN       = 8'(WINDOW_FRAMES);
  localparam logic [7:0] WIN_LAST  = 8'(WINDOW_FRAMES - 1);
  localparam logic [7:0] COOL_INIT = 8'(HIT_COOLDOWN);

  state_e     state_q;
  logic [7:0] atk_q;
  logic [7:0] acc_q;
  logic [7:0] frame_q;
  logic [7:0] cool_q;
  logic       heal_flag_q;
  logic       done_q;
  logic [7:0] damage_q;
  logic       heal_q;
  logic       busy_q;
  logic [7:0] frames_left_q;

  logic       in_dodge_s;
  logic       hit_s;
  logic [7:0] acc_d;
  logic [7:0] cool_d;
  logic       heal_d;

  // Sum computed at 9 bits so the carry out selects the 255 ceiling.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[8]) begin
      sat_add = 8'hFF;
    end else begin
      sat_add = sum[7:0];
    end
  endfunction

  // Hit acceptance, cooldown and heal next-state; a hit sees the pre-decrement cooldown.
  always_comb begin
    in_dodge_s = (state_q == DODGE);
    hit_s      = in_dodge_s && dmg.playerHit && (cool_q == 8'd0);
    acc_d      = acc_q;
    cool_d     = cool_q;
    heal_d     = heal_flag_q;
    if (hit_s) begin
      acc_d  = sat_add(acc_q, atk_q);
      cool_d = COOL_INIT;
    end else if (in_dodge_s && dmg.tick && (cool_q != 8'd0)) begin
      acc_d  = acc_q;
      cool_d = cool_q - 8'd1;
    end else begin
      acc_d  = acc_q;
      cool_d = cool_q;
    end
    if (in_dodge_s && dmg.healPickup) begin
      heal_d = 1'b1;
    end else begin
      heal_d = heal_flag_q;
    end
  end

  // Window state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      atk_q         <= 8'd0;
      acc_q         <= 8'd0;
      frame_q       <= 8'd0;
      cool_q        <= 8'd0;
      heal_flag_q   <= 1'b0;
      done_q        <= 1'b0;
      damage_q      <= 8'd0;
      heal_q        <= 1'b0;
      busy_q        <= 1'b0;
      frames_left_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q        <= 1'b0;
          damage_q      <= 8'd0;
          heal_q        <= 1'b0;
          frames_left_q <= 8'd0;
          if (dmg.startDmg) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        ARM: begin
          atk_q         <= dmg.monATK;
          acc_q         <= 8'd0;
          frame_q       <= 8'd0;
          cool_q        <= 8'd0;
          heal_flag_q   <= 1'b0;
          busy_q        <= 1'b1;
          frames_left_q <= WIN;
          state_q       <= DODGE;
        end
        DODGE: begin
          acc_q       <= acc_d;
          cool_q      <= cool_d;
          heal_flag_q <= heal_d;
          if (dmg.tick && (frame_q == WIN_LAST)) begin
            // Final-frame events are already folded into acc_d/heal_d.
            state_q       <= REPORT;
            done_q        <= 1'b1;
            damage_q      <= acc_d;
            heal_q        <= heal_d;
            frames_left_q <= 8'd0;
          end else if (dmg.tick) begin
            frame_q       <= frame_q + 8'd1;
            frames_left_q <= WIN - (frame_q + 8'd1);
          end else begin
            frame_q <= frame_q;
          end
        end
        REPORT: begin
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          damage_q <= 8'd0;
          heal_q   <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          busy_q        <= 1'b0;
          done_q        <= 1'b0;
          damage_q      <= 8'd0;
          heal_q        <= 1'b0;
          frames_left_q <= 8'd0;
        end
      endcase
    end
  end

  assign dmg.isDmgComplete = done_q;
  assign dmg.damage        = damage_q;
  assign dmg.heal          = heal_q;
  assign dmg.busy          = busy_q;
  assign dmg.framesLeft    = frames_left_q;

endmodule

// File: tb/tb_damage_resolver.sv
// Directed cycle-by-cycle vectors for damage_resolver with WINDOW_FRAMES=4, HIT_COOLDOWN=2,
// plus hand-written reset-abandon and fresh-request sequences.
module tb_damage_resolver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  damage_resolver_if dif();

  damage_resolver #(
    .WINDOW_FRAMES(4),
    .HIT_COOLDOWN (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dmg  (dif)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [7:0] atk;
    logic       tick;
    logic       hit;
    logic       hp;
    logic       e_done;
    logic [7:0] e_dmg;
    logic       e_heal;
    logic       e_busy;
    logic [7:0] e_fl;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic r, input logic s, input logic [7:0] a, input logic t,
                     input logic h, input logic p, input logic d, input logic [7:0] dm,
                     input logic he, input logic b, input logic [7:0] f);
    vec_t v;
    v = '{r, s, a, t, h, p, d, dm, he, b, f};
    vq.push_back(v);
  endtask

  function automatic logic [18:0] outs();
    return {dif.isDmgComplete, dif.damage, dif.heal, dif.busy, dif.framesLeft};
  endfunction

  task automatic chk(input string name, input logic [18:0] want);
    logic [18:0] got;
    got = outs();
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: done/dmg/heal/busy/left got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
               name, got[18], got[17:10], got[9], got[8], got[7:0],
               want[18], want[17:10], want[9], want[8], want[7:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic [7:0] a, input logic t,
                       input logic h, input logic p);
    reset          = r;
    dif.startDmg   = s;
    dif.monATK     = a;
    dif.tick       = t;
    dif.playerHit  = h;
    dif.healPickup = p;
  endtask

  initial begin
    int          lat;
    logic [18:0] at_done;

    drive(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset, then idle with tick/hit/heal active: nothing happens.
    add(1, 0,   0, 1, 1, 1,  0,   0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 0);
    // ATK=10, no hits: completion 6 cycles after the start edge.
    add(0, 1,  10, 1, 0, 0,  0,   0, 0, 1, 0);
    add(0, 0,  10, 1, 0, 0,  0,   0, 0, 1, 4);
    add(0, 0,  10, 1, 0, 0,  0,   0, 0, 1, 3);
    add(0, 0,  10, 1, 0, 0,  0,   0, 0, 1, 2);
    add(0, 0,  10, 1, 0, 0,  0,   0, 0, 1, 1);
    add(0, 0,  10, 1, 0, 0,  1,   0, 0, 1, 0);
    add(0, 0,  10, 1, 0, 0,  0,   0, 0, 0, 0);
    // ATK=10, hit held: frames 0 and 3 accepted -> 20; start during REPORT dropped.
    add(0, 1,  10, 1, 1, 0,  0,   0, 0, 1, 0);
    add(0, 0,  10, 1, 1, 0,  0,   0, 0, 1, 4);
    add(0, 0,  10, 1, 1, 0,  0,   0, 0, 1, 3);
    add(0, 0,  10, 1, 1, 0,  0,   0, 0, 1, 2);
    add(0, 0,  10, 1, 1, 0,  0,   0, 0, 1, 1);
    add(0, 0,  10, 1, 1, 0,  1,  20, 0, 1, 0);
    add(0, 1,  10, 1, 1, 0,  0,   0, 0, 0, 0);
    add(0, 0,  10, 1, 1, 0,  0,   0, 0, 0, 0);
    // ATK latched in ARM as 200; saturation to 255; heal with hit on final frame; start in DODGE dropped.
    add(0, 1,   7, 1, 0, 0,  0,   0, 0, 1, 0);
    add(0, 0, 200, 1, 0, 0,  0,   0, 0, 1, 4);
    add(0, 0,  99, 1, 1, 0,  0,   0, 0, 1, 3);
    add(0, 1,  99, 1, 0, 0,  0,   0, 0, 1, 2);
    add(0, 0,  99, 1, 0, 0,  0,   0, 0, 1, 1);
    add(0, 0,  99, 1, 1, 1,  1, 255, 1, 1, 0);
    add(0, 0,  99, 1, 0, 0,  0,   0, 0, 0, 0);
    add(0, 0,  99, 1, 0, 0,  0,   0, 0, 0, 0);
    // Sparse ticks: hits between ticks, cooldown only counts down on ticks.
    add(0, 1,   5, 0, 0, 0,  0,   0, 0, 1, 0);
    add(0, 0,   5, 0, 0, 0,  0,   0, 0, 1, 4);
    add(0, 0,   5, 0, 1, 0,  0,   0, 0, 1, 4);
    add(0, 0,   5, 1, 1, 0,  0,   0, 0, 1, 3);
    add(0, 0,   5, 1, 0, 1,  0,   0, 0, 1, 2);
    add(0, 0,   5, 0, 1, 0,  0,   0, 0, 1, 2);
    add(0, 0,   5, 1, 0, 0,  0,   0, 0, 1, 1);
    add(0, 0,   5, 1, 0, 0,  1,  10, 1, 1, 0);
    add(0, 0,   5, 0, 0, 0,  0,   0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].start, vq[i].atk, vq[i].tick, vq[i].hit, vq[i].hp);
      step();
      chk($sformatf("vec%0d", i),
          {vq[i].e_done, vq[i].e_dmg, vq[i].e_heal, vq[i].e_busy, vq[i].e_fl});
    end

    // Reset in the middle of DODGE abandons the window without a completion.
    drive(1'b0, 1'b1, 8'd50, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'd50, 1'b1, 1'b1, 1'b0);
    step();
    step();
    chk("mid_dodge_busy", {1'b0, 8'd0, 1'b0, 1'b1, 8'd3});
    drive(1'b1, 1'b0, 8'd50, 1'b1, 1'b1, 1'b0);
    step();
    chk("reset_clears", 19'd0);
    drive(1'b0, 1'b0, 8'd50, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("after_reset%0d", i), 19'd0);
    end

    // Fresh request completes normally with a newly latched ATK (hit held -> 2 hits).
    drive(1'b0, 1'b1, 8'd30, 1'b1, 1'b1, 1'b0);
    lat     = 0;
    at_done = 19'd0;
    for (int i = 1; i <= 20; i++) begin
      step();
      dif.startDmg = 1'b0;
      if (dif.isDmgComplete && (lat == 0)) begin
        lat     = i;
        at_done = outs();
      end
    end
    n_vec++;
    if (lat != 6) begin
      n_miss++;
      $display("FAIL fresh_latency: got %0d cycles want 6 (0 = no completion within 20)", lat);
    end
    n_vec++;
    if (at_done !== {1'b1, 8'd60, 1'b0, 1'b1, 8'd0}) begin
      n_miss++;
      $display("FAIL fresh_report: got done=%0d dmg=%0d heal=%0d busy=%0d want 1/60/0/1",
               at_done[18], at_done[17:10], at_done[9], at_done[8]);
    end
    chk("fresh_idle", 19'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/damage_resolver.md
# damage_resolver

Responder side of the Machine's damage handshake. On a `startDmg` pulse from the Machine it runs the monster's attack window: it counts frame ticks, accepts bullet-collision hits with an invulnerability cooldown, and accumulates saturating damage from the latched monster ATK. It also records heal pickups. At window end it returns `damage`, `heal` and a one-cycle `isDmgComplete` to the Machine, which then updates player HP and leaves the attack state.

## Interface
- `WINDOW_FRAMES`, 120: length of the attack window in `tick` frames; legal range 1..255.
- `HIT_COOLDOWN`, 8: frames after an accepted hit during which further hits are ignored; 0 disables the cooldown.
- `clk` input 1: system clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-high.
- `startDmg` input 1: one-cycle request from the Machine; honoured only in IDLE.
- `monATK` input 8: monster attack per hit; sampled in ARM only.
- `tick` input 1: one-cycle frame strobe.
- `playerHit` input 1: one-cycle collision pulse from the bullet logic.
- `healPickup` input 1: one-cycle heal-item pulse.
- `isDmgComplete` output 1: one-cycle completion pulse to the Machine.
- `damage` output 8: total damage; valid only while `isDmgComplete`=1, else 0.
- `heal` output 1: at least one pickup during the window; valid only while `isDmgComplete`=1, else 0.
- `busy` output 1: high in ARM, DODGE and REPORT.
- `framesLeft` output 8: `WINDOW_FRAMES` minus frames elapsed while in DODGE, else 0; used for the on-screen timer.

## Operation
- State machine states:
  - IDLE: waits for `startDmg`, then goes to ARM.
  - ARM: one cycle. Latches `monATK`, clears the accumulator, the frame counter, the cooldown and the heal flag. Goes to DODGE.
  - DODGE: runs the window. When `tick`=1 and frame counter = `WINDOW_FRAMES`-1, goes to REPORT.
  - REPORT: one cycle. Drives `isDmgComplete`=1 with `damage`=accumulator and `heal`=flag. Goes to IDLE.
- Frame counter: 8-bit; increments on each `tick` in DODGE.
- Hit acceptance:
  - A hit is accepted when state is DODGE, `playerHit`=1 and cooldown=0.
  - On acceptance: accumulator ← min(accumulator + latched ATK, 255), computed at 9 bits and saturated; cooldown ← `HIT_COOLDOWN`.
- Cooldown: decrements by 1 on each `tick` while nonzero. A hit in the same cycle as a decrement sees the pre-decrement value.
- Heal: `healPickup` in DODGE sets the heal flag (sticky for the window).
- Inputs outside DODGE: `playerHit`, `healPickup` and `tick` are ignored in IDLE, ARM and REPORT.
- Simultaneous events:
  - `playerHit` and `healPickup` in the same cycle are both honoured.
  - Events on the final window tick are counted before REPORT.
- `startDmg` while `busy`=1 is dropped; it is not queued.
- ATK=0: hits still start the cooldown; damage stays 0.
- Reset: any state returns to IDLE. All counters, the accumulator and the flag clear. All outputs go to 0 on the next edge. A window in progress is abandoned and no completion is issued.

## Timing
- Reset values: `isDmgComplete`=0, `damage`=0, `heal`=0, `busy`=0, `framesLeft`=0.
- `startDmg` sampled at edge N → ARM at N+1 (`busy`=1) → DODGE at N+2 (`framesLeft`=`WINDOW_FRAMES`).
- Final `tick` sampled at edge M → REPORT at M+1, `isDmgComplete` high for exactly one cycle → IDLE at M+2 (`busy`=0).
- With a tick every cycle from N+2 onward, `isDmgComplete` rises at N+2+`WINDOW_FRAMES`.
- `framesLeft` updates the cycle after each counted tick.
- Back-to-back requests: a `startDmg` in the IDLE cycle right after REPORT is accepted. Minimum request spacing is `WINDOW_FRAMES`+3 cycles.

## Test plan
- Bench parameters: `WINDOW_FRAMES`=4, `HIT_COOLDOWN`=2, `tick` every cycle.
- Reset, then idle for 5 cycles → all outputs 0. Hold `playerHit`=1 in IDLE → no effect.
- `monATK`=10, `startDmg` pulse, no hits → `isDmgComplete` one cycle exactly 6 cycles after the `startDmg` edge, `damage`=0, `heal`=0.
- `monATK`=10, `playerHit` held high through the whole window → hits accepted on DODGE frames 0 and 3 only (cooldown). `damage`=20.
- `monATK`=200, hits on frames 0 and 3 → `damage`=255 (saturated). `healPickup` on the final frame together with a hit → `heal`=1 and the hit is counted.
- `startDmg` pulsed again during DODGE → ignored, single completion. `reset` asserted mid-DODGE → no completion pulse. A fresh `startDmg` afterwards completes normally with a newly latched ATK.
